// File: rtl/uart_rx.sv
// UART receiver: 16x-oversampled start/data/stop framing, LSB-first; optional even parity via UART_RX_PARITY_EN.
// Latency: 2-cycle input synchronizer; done/error pulses registered one cycle after the final stop-bit tick.
// Backpressure: none; o_data holds until the next good frame and each pulse lasts exactly one cycle.
module uart_rx #(
    parameter int DATA_BITS = 8,
    parameter int SB_TICKS  = 16
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_tick,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_rx_done,
`ifdef UART_RX_PARITY_EN
    output logic                 o_parity_err,
`endif
    output logic                 o_frame_err
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    localparam logic [4:0] SB_LAST  = 5'(SB_TICKS - 1);
    localparam logic [3:0] BIT_LAST = 4'(DATA_BITS - 1);

    logic                 rx_meta;
    logic                 rx_s;
    logic [2:0]           state;
    logic [4:0]           tick_cnt;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg;
`ifdef UART_RX_PARITY_EN
    logic                 par_err;
`endif

    // Synchronizer resets to the idle-high line level so reset never looks like a start bit.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state       <= IDLE;
            tick_cnt    <= 5'd0;
            bit_cnt     <= 4'd0;
            shreg       <= '0;
            o_data      <= '0;
            o_rx_done   <= 1'b0;
            o_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err      <= 1'b0;
            o_parity_err <= 1'b0;
`endif
        end else begin
            o_rx_done   <= 1'b0;
            o_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            o_parity_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state    <= START;
                        tick_cnt <= 5'd0;
                    end
                end
                START: begin
                    if (i_tick) begin
                        if (tick_cnt == 5'd7) begin
                            // Mid start bit: a line that has gone high again was a glitch.
                            state    <= rx_s ? IDLE : DATA;
                            tick_cnt <= 5'd0;
                            bit_cnt  <= 4'd0;
                        end else begin
                            tick_cnt <= tick_cnt + 5'd1;
                        end
                    end
                end
                DATA: begin
                    if (i_tick) begin
                        if (tick_cnt == 5'd15) begin
                            tick_cnt <= 5'd0;
                            shreg    <= {rx_s, shreg[DATA_BITS-1:1]};
                            if (bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                                state <= PARITY;
`else
                                state <= STOP;
`endif
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 5'd1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (i_tick) begin
                        if (tick_cnt == 5'd15) begin
                            tick_cnt <= 5'd0;
                            par_err  <= (^shreg) ^ rx_s;
                            state    <= STOP;
                        end else begin
                            tick_cnt <= tick_cnt + 5'd1;
                        end
                    end
                end
`endif
                STOP: begin
                    if (i_tick) begin
                        if (tick_cnt == SB_LAST) begin
                            state    <= IDLE;
                            tick_cnt <= 5'd0;
                            if (rx_s) begin
`ifdef UART_RX_PARITY_EN
                                if (!par_err) begin
                                    o_data    <= shreg;
                                    o_rx_done <= 1'b1;
                                end
`else
                                o_data    <= shreg;
                                o_rx_done <= 1'b1;
`endif
                            end else begin
                                o_frame_err <= 1'b1;
                            end
`ifdef UART_RX_PARITY_EN
                            o_parity_err <= par_err;
`endif
                        end else begin
                            tick_cnt <= tick_cnt + 5'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: framed bytes, back-to-back frames, glitch, framing error, mid-frame reset, optional parity.
module tb_uart_rx;

    logic       i_clock = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_tick  = 1'b0;
    logic       i_rx    = 1'b1;
    logic [7:0] o_data;
    logic       o_rx_done;
    logic       o_frame_err;
`ifdef UART_RX_PARITY_EN
    logic       o_parity_err;
`endif

    uart_rx #(.DATA_BITS(8), .SB_TICKS(16)) dut (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_tick     (i_tick),
        .i_rx       (i_rx),
        .o_data     (o_data),
        .o_rx_done  (o_rx_done),
`ifdef UART_RX_PARITY_EN
        .o_parity_err(o_parity_err),
`endif
        .o_frame_err(o_frame_err)
    );

    always #5 i_clock = ~i_clock;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int done_cnt = 0;
    int ferr_cnt = 0;
    int perr_cnt = 0;
    int both_seen = 0;
    int last_done_cyc = 0;
    int start_cyc = 0;
    logic [7:0] log_q[$];

    always @(posedge i_clock) cyc <= cyc + 1;

    // One tick every 16 clocks, driven just after an edge.
    initial begin
        forever begin
            repeat (15) @(posedge i_clock);
            #1 i_tick = 1'b1;
            @(posedge i_clock);
            #1 i_tick = 1'b0;
        end
    end

    always @(negedge i_clock) begin
        if (o_rx_done) begin
            done_cnt++;
            log_q.push_back(o_data);
            last_done_cyc = cyc;
        end
        if (o_frame_err) ferr_cnt++;
        if (o_rx_done && o_frame_err) both_seen = 1;
`ifdef UART_RX_PARITY_EN
        if (o_parity_err) perr_cnt++;
`endif
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic hold(input logic b, input int n);
        i_rx = b;
        repeat (n) @(posedge i_clock);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_hi,
                              input logic par_on, input logic par_bit);
        start_cyc = cyc;
        hold(1'b0, 256);
        for (int i = 0; i < 8; i++) hold(d[i], 256);
        if (par_on) hold(par_bit, 256);
        if (stop_hi) begin
            hold(1'b1, 256);
        end else begin
            // Low across the stop-bit sample, then released before the re-armed start check.
            hold(1'b0, 160);
            hold(1'b1, 96);
        end
    endtask

    function automatic logic [15:0] log_at(input int idx);
        if (idx < log_q.size()) return {8'h00, log_q[idx]};
        return 16'hFFFF;
    endfunction

    int d0, f0, p0, n0, lat;

    initial begin
        repeat (5) @(posedge i_clock);
        #1 i_reset = 1'b0;
        check("rst_data", o_data, 0);
        check("rst_done", o_rx_done, 0);
        check("rst_ferr", o_frame_err, 0);
        hold(1'b1, 64);

        // 0xA5, 8N1
        d0 = done_cnt; f0 = ferr_cnt;
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        hold(1'b1, 512);
        lat = last_done_cyc - start_cyc;
        check("a5_done", done_cnt - d0, 1);
        check("a5_data", o_data, 8'hA5);
        check("a5_ferr", ferr_cnt - f0, 0);
        check("a5_latency", (lat >= 2420 && lat <= 2435), 1);

        // 0x00 then 0xFF with no idle gap
        d0 = done_cnt; f0 = ferr_cnt; n0 = log_q.size();
        send_frame(8'h00, 1'b1, 1'b0, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0, 1'b0);
        hold(1'b1, 512);
        check("b2b_done", done_cnt - d0, 2);
        check("b2b_first", log_at(n0), 16'h0000);
        check("b2b_second", log_at(n0 + 1), 16'h00FF);
        check("b2b_ferr", ferr_cnt - f0, 0);

        // Start glitch lasting 3 ticks
        d0 = done_cnt; f0 = ferr_cnt;
        hold(1'b0, 48);
        hold(1'b1, 3000);
        check("glitch_done", done_cnt - d0, 0);
        check("glitch_ferr", ferr_cnt - f0, 0);
        check("glitch_data", o_data, 8'hFF);

        // 0x3C with a low stop bit
        d0 = done_cnt; f0 = ferr_cnt;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        hold(1'b1, 3000);
        check("ferr_pulse", ferr_cnt - f0, 1);
        check("ferr_done", done_cnt - d0, 0);
        check("ferr_data", o_data, 8'hFF);

        // Reset during data bit 4 of 0x81, then 0x5A
        hold(1'b0, 256);
        for (int i = 0; i < 4; i++) hold(1'(8'h81 >> i), 256);
        hold(1'b0, 128);
        i_reset = 1'b1;
        i_rx    = 1'b1;
        @(posedge i_clock);
        #1 i_reset = 1'b0;
        check("mrst_data", o_data, 0);
        check("mrst_done", o_rx_done, 0);
        check("mrst_ferr", o_frame_err, 0);
        d0 = done_cnt; f0 = ferr_cnt;
        hold(1'b1, 1);
        check("mrst_next_done", o_rx_done, 0);
        hold(1'b1, 3000);
        check("mrst_quiet", (done_cnt - d0) + (ferr_cnt - f0), 0);
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
        hold(1'b1, 512);
        check("post_rst_done", done_cnt - d0, 1);
        check("post_rst_data", o_data, 8'h5A);

`ifdef UART_RX_PARITY_EN
        d0 = done_cnt; p0 = perr_cnt;
        send_frame(8'h07, 1'b1, 1'b1, 1'b0);
        hold(1'b1, 512);
        check("par_bad_perr", perr_cnt - p0, 1);
        check("par_bad_done", done_cnt - d0, 0);
        d0 = done_cnt; p0 = perr_cnt;
        send_frame(8'h07, 1'b1, 1'b1, 1'b1);
        hold(1'b1, 512);
        check("par_ok_done", done_cnt - d0, 1);
        check("par_ok_data", o_data, 8'h07);
        check("par_ok_perr", perr_cnt - p0, 0);
`else
        p0 = perr_cnt;
`endif

        check("done_ferr_exclusive", both_seen, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
